// File: rtl/ro_puf_axi4l_slave_if.sv
// rtl/ro_puf_axi4l_slave_if.sv - AXI4-Lite bus bundle for the RO-PUF register slave
interface ro_puf_axi4l_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/ro_puf_axi4l_slave.sv
// rtl/ro_puf_axi4l_slave.sv - AXI4-Lite register slave launching RO-PUF evaluations
module ro_puf_axi4l_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CHAL_WIDTH         = 32,
    parameter int RESP_WIDTH         = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    ro_puf_axi4l_slave_if.slave   s_axi,
    output logic                  puf_start,
    output logic [CHAL_WIDTH-1:0] puf_challenge,
    input  logic                  puf_done,
    input  logic [RESP_WIDTH-1:0] puf_response
);
    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_CHAL   = 2'd1;
    localparam logic [1:0] SEL_RESP   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_awready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [31:0] r_ctrl;
    logic [31:0] r_chal;
    logic [RESP_WIDTH-1:0] r_resp;
    logic        r_done;
    logic [7:0]  r_eval_cnt;
    logic        r_puf_start;

    logic        w_wr_en;
    logic [1:0]  w_wr_sel;
    logic [1:0]  w_rd_sel;
    logic        w_start_req;
    logic        w_launch;
    logic        w_capture;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // AW/W are accepted as a pair; the address and data are still presented while ready is high
    assign w_wr_en     = r_awready;
    assign w_wr_sel    = s_axi.S_AXI_AWADDR[3:2];
    assign w_rd_sel    = s_axi.S_AXI_ARADDR[3:2];
    assign w_start_req = w_wr_en && (w_wr_sel == SEL_CTRL) &&
                         s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[0];
    assign w_unused    = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_req) begin
                    w_state_nxt = ST_BUSY;
                    w_launch    = 1'b1;
                end
            end
            ST_BUSY: begin
                // completion wins; a START arriving in the same cycle is simply dropped
                if (puf_done) begin
                    w_state_nxt = ST_IDLE;
                    w_capture   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_rd_sel)
            SEL_CTRL:   w_rd_mux = {r_ctrl[31:1], 1'b0};
            SEL_CHAL:   w_rd_mux = r_chal;
            SEL_RESP:   w_rd_mux = 32'(r_resp);
            SEL_STATUS: w_rd_mux = {16'h0, r_eval_cnt, 6'h0, r_done, r_state == ST_BUSY};
            default:    w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready   <= 1'b0;
            r_bvalid    <= 1'b0;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= 32'h0;
            r_ctrl      <= 32'h0;
            r_chal      <= 32'h0;
            r_resp      <= '0;
            r_done      <= 1'b0;
            r_eval_cnt  <= 8'h0;
            r_puf_start <= 1'b0;
        end else begin
            r_awready <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !r_bvalid && !r_awready;
            if (r_awready) begin
                r_bvalid <= 1'b1;
            end else if (s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            if (w_wr_en) begin
                case (w_wr_sel)
                    SEL_CTRL: r_ctrl <= strb_merge(r_ctrl, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB) & 32'hFFFF_FFFE;
                    SEL_CHAL: r_chal <= strb_merge(r_chal, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                    default:  ;
                endcase
            end

            // RDATA is sampled at the same edge a write commits, so a colliding read sees the old value
            r_arready <= s_axi.S_AXI_ARVALID && !r_rvalid && !r_arready;
            if (r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end

            r_puf_start <= w_launch;
            if (w_launch) begin
                r_done <= 1'b0;
            end
            if (w_capture) begin
                r_resp     <= puf_response;
                r_done     <= 1'b1;
                r_eval_cnt <= r_eval_cnt + 8'd1;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_awready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign puf_start           = r_puf_start;
    assign puf_challenge       = r_chal[CHAL_WIDTH-1:0];
endmodule

// File: tb/tb_ro_puf_axi4l_slave.sv
// tb/tb_ro_puf_axi4l_slave.sv - self-checking bench for the RO-PUF AXI4-Lite slave
module tb_ro_puf_axi4l_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        puf_start;
    logic [31:0] puf_challenge;
    logic        puf_done;
    logic [31:0] puf_response;

    logic        auto_done = 1'b0;
    logic [31:0] auto_resp = 32'h0;
    logic        man_done = 1'b0;
    logic [31:0] man_resp = 32'h0;
    bit          puf_auto = 1'b0;
    bit          puf_pending = 1'b0;
    int          puf_delay = 20;
    logic [31:0] auto_val = 32'h0;
    int          start_pulses = 0;
    int          checks = 0;
    int          failures = 0;

    ro_puf_axi4l_slave_if bus ();

    ro_puf_axi4l_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .puf_start     (puf_start),
        .puf_challenge (puf_challenge),
        .puf_done      (puf_done),
        .puf_response  (puf_response)
    );

    always #5 clk = ~clk;

    assign puf_done     = auto_done | man_done;
    assign puf_response = auto_done ? auto_resp : man_resp;

    always @(negedge clk) if (puf_start) start_pulses++;

    // PUF core model: answers each start after puf_delay cycles with auto_val
    initial begin
        forever begin
            @(negedge clk);
            if (puf_start && puf_auto) begin
                puf_pending = 1'b1;
                repeat (puf_delay - 1) @(negedge clk);
                auto_resp = auto_val;
                auto_done = 1'b1;
                @(negedge clk);
                auto_done   = 1'b0;
                puf_pending = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr_req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit done_at_accept, input logic [31:0] dresp);
        bit ok;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.S_AXI_AWREADY;
        end
        if (!ok) chk("aw_timeout", 32'h0, 32'h1);
        if (done_at_accept) begin
            man_resp = dresp;
            man_done = 1'b1;
        end
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        man_done = 1'b0;
    endtask

    task automatic wait_b();
        bit ok;
        bus.S_AXI_BREADY = 1'b1;
        ok = bus.S_AXI_BVALID;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.S_AXI_BVALID;
        end
        if (!ok) chk("b_timeout", 32'h0, 32'h1);
        else chk("bresp", 32'(bus.S_AXI_BRESP), 32'h0);
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_req(a, d, s, 1'b0, 32'h0);
        wait_b();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bit ok;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.S_AXI_ARREADY;
        end
        if (!ok) chk("ar_timeout", 32'h0, 32'h1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;
        ok = bus.S_AXI_RVALID;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.S_AXI_RVALID;
        end
        if (!ok) chk("r_timeout", 32'h0, 32'h1);
        else chk("rresp", 32'(bus.S_AXI_RRESP), 32'h0);
        d = bus.S_AXI_RDATA;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic wait_puf_idle();
        bit ok;
        ok = !puf_pending;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !puf_pending;
        end
        if (!ok) chk("puf_timeout", 32'h0, 32'h1);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // reference model of the register file, used for the randomized phase
    logic [31:0] m_ctrl, m_chal, m_resp;
    bit          m_done;
    int          m_cnt;

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r = (r & ~(32'hFF << (8 * b))) | (n & (32'hFF << (8 * b)));
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'h0:    return m_ctrl & 32'hFFFF_FFFE;
            4'h4:    return m_chal;
            4'h8:    return m_resp;
            default: return ((m_cnt % 256) * 256) + (m_done ? 2 : 0);
        endcase
    endfunction

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] d;
        int          p0;
        bit          stable;

        vt[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0000};
        vt[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vt[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0000};
        vt[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0001};
        vt[4] = '{4'h4, 32'h0000_0000, 4'hF, 32'h0000_0000};
        vt[5] = '{4'h4, 32'hA5A5_F00F, 4'h3, 32'h0000_F00F};
        vt[6] = '{4'h0, 32'hABCD_0001, 4'hC, 32'hABCD_0000};
        vt[7] = '{4'h0, 32'h0000_00FF, 4'h1, 32'hABCD_00FE};

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        #200;
        @(negedge clk);
        chk("rst_outputs", {26'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                            bus.S_AXI_ARREADY, bus.S_AXI_RVALID, puf_start}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("rst_status", 4'hC, 32'h0);
        chk("rst_challenge", puf_challenge, 32'h0);

        // table: write then read back, PUF core held silent so the launch stays busy
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].addr, vt[i].data, vt[i].strb);
            rd_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
        end
        chk("challenge_f00f", puf_challenge, 32'h0000_F00F);
        chk("one_start_pulse", 32'(start_pulses), 32'd1);

        // START and puf_done landing together while busy: capture wins, no new launch
        wr_req(4'h0, 32'h1, 4'h1, 1'b1, 32'h1234_5678);
        wait_b();
        rd_chk("same_cycle_status", 4'hC, 32'h0000_0102);
        rd_chk("same_cycle_resp", 4'h8, 32'h1234_5678);
        chk("same_cycle_pulses", 32'(start_pulses), 32'd1);

        // stray puf_done in IDLE
        man_resp = 32'h55; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        rd_chk("idle_done_resp", 4'h8, 32'h1234_5678);
        rd_chk("idle_done_status", 4'hC, 32'h0000_0102);

        // automatic PUF answering after 20 cycles, second START while busy
        puf_auto = 1'b1; puf_delay = 20; auto_val = 32'hDEAD_BEEF;
        wr(4'h0, 32'h1, 4'h1);
        chk("start2_pulses", 32'(start_pulses), 32'd2);
        rd_chk("busy_status", 4'hC, 32'h0000_0101);
        wr(4'h0, 32'h1, 4'h1);
        wait_puf_idle();
        rd_chk("eval_status", 4'hC, 32'h0000_0202);
        rd_chk("eval_resp", 4'h8, 32'hDEAD_BEEF);
        chk("busy_start_ignored", 32'(start_pulses), 32'd2);

        // back-pressure on B and R
        wr_req(4'h4, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0);
        bus.S_AXI_ARADDR = 4'h4; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'hFFFF_FFFF; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 4'h0; bus.S_AXI_ARVALID = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.S_AXI_BVALID || !bus.S_AXI_RVALID || bus.S_AXI_RDATA !== 32'h1357_9BDF ||
                bus.S_AXI_AWREADY || bus.S_AXI_ARREADY)
                stable = 1'b0;
        end
        chk("backpressure_stable", 32'(stable), 32'h1);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        chk("bp_release", {30'h0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h0);
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        rd_chk("bp_chal", 4'h4, 32'h1357_9BDF);

        // reset in the middle of an evaluation with a B response pending
        wr(4'h0, 32'h1, 4'h1);
        repeat (3) @(negedge clk);
        wr_req(4'h4, 32'h99, 4'hF, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {29'h0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, puf_start}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("midreset_status", 4'hC, 32'h0);
        repeat (30) @(negedge clk);
        rd_chk("midreset_late_status", 4'hC, 32'h0);
        rd_chk("midreset_late_resp", 4'h8, 32'h0);

        // 256 evaluations wrap eval_cnt
        puf_delay = 1;
        for (int i = 0; i < 256; i++) begin
            auto_val = 32'(i);
            wr(4'h0, 32'h1, 4'h1);
            wait_puf_idle();
            if (i == 254) rd_chk("cnt_255", 4'hC, 32'h0000_FF02);
        end
        rd_chk("cnt_wrap", 4'hC, 32'h0000_0002);
        rd_chk("wrap_resp", 4'h8, 32'h0000_00FF);

        // randomized traffic against the reference model
        do_reset(2);
        m_ctrl = 0; m_chal = 0; m_resp = 0; m_done = 0; m_cnt = 0;
        p0 = start_pulses;
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  a;
            logic [31:0] wd;
            logic [3:0]  ws;
            a = 4'(($urandom_range(0, 3)) * 4);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; ws = 4'($urandom_range(0, 15));
                auto_val = $urandom; puf_delay = $urandom_range(1, 8);
                wr(a, wd, ws);
                if (a == 4'h0) m_ctrl = m_merge(m_ctrl, wd, ws);
                if (a == 4'h4) m_chal = m_merge(m_chal, wd, ws);
                if (a == 4'h0 && ws[0] && wd[0]) begin
                    wait_puf_idle();
                    m_done = 1; m_cnt++; m_resp = auto_val;
                end
                chk("rand_challenge", puf_challenge, m_chal);
            end else begin
                rd(a, d);
                chk($sformatf("rand_rd_%0h", a), d, m_read(a));
            end
        end
        chk("rand_pulses", 32'(start_pulses - p0), 32'(m_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
